// File: rtl/alu32_pkg.sv
// Shared definitions for the 32-bit ALU datapath blocks.
//   WORD_W    : datapath width
//   SPLIT_DEF : default bit position of the carry-chain pipeline cut
//   s1_payload_t : stage-1 register contents of the pipelined subtractor
package alu32_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned SPLIT_DEF = 16;

   // lo is kept zero-extended to the full word so stage 2 can assemble the
   // result with a plain OR of the high slice, independent of the cut position.
   typedef struct packed {
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] b;
      logic [WORD_W-1:0] lo;
      logic              c_mid;
      logic              uns;
   } s1_payload_t;

endpackage

// File: rtl/add_slice.sv
// Ripple-style adder slice with carry in/out.
//   x, y : WIDTH-bit addends
//   cin  : carry in
//   sum  : WIDTH-bit sum
//   cout : carry out of the top bit
module add_slice #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] full;

   // One extra bit holds the carry out of the slice.
   assign full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
   assign sum  = full[WIDTH-1:0];
   assign cout = full[WIDTH];

endmodule

// File: rtl/sub_pipe_32.sv
// Two-stage pipelined 32-bit subtractor, A - B = A + ~B + 1, with the carry
// chain cut at bit SPLIT. Valid/ready on both sides, 1 op/cycle throughput.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : upstream handshake
//   a_in, b_in            : minuend, subtrahend
//   unsigned_in           : SLTU select, carried with the data
//   out_valid / out_ready : downstream handshake
//   a_out, b_out          : operands aligned with the result
//   sub_z                 : A - B modulo 2^32
//   carryout              : carry out of bit 31 (1 = no borrow)
//   overflow              : signed overflow of the subtraction
//   unsigned_out          : aligned unsigned_in
module sub_pipe_32
   import alu32_pkg::*;
#(
   parameter int unsigned SPLIT = SPLIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a_in,
   input  logic [WORD_W-1:0] b_in,
   input  logic              unsigned_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] a_out,
   output logic [WORD_W-1:0] b_out,
   output logic [WORD_W-1:0] sub_z,
   output logic              carryout,
   output logic              overflow,
   output logic              unsigned_out
);

   localparam int unsigned HI_W = WORD_W - SPLIT;

   // Stage 1 state
   s1_payload_t s1_q, s1_d;
   logic        s1_valid_q, s1_valid_d;

   // Stage 2 (output) state
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] a_out_q, a_out_d;
   logic [WORD_W-1:0] b_out_q, b_out_d;
   logic [WORD_W-1:0] sub_z_q, sub_z_d;
   logic              carry_q, carry_d;
   logic              ovf_q, ovf_d;
   logic              uns_q, uns_d;

   logic adv2;
   logic accept;

   // Low slice works on the incoming operands; B inversion done here.
   logic [SPLIT-1:0] lo_sum;
   logic             lo_cout;

   add_slice #(
      .WIDTH (SPLIT)
   ) u_lo (
      .x    (a_in[SPLIT-1:0]),
      .y    (~b_in[SPLIT-1:0]),
      .cin  (1'b1),
      .sum  (lo_sum),
      .cout (lo_cout)
   );

   // High slice finishes the chain from the registered mid carry.
   logic [HI_W-1:0] hi_sum;
   logic            hi_cout;

   add_slice #(
      .WIDTH (HI_W)
   ) u_hi (
      .x    (s1_q.a[WORD_W-1:SPLIT]),
      .y    (~s1_q.b[WORD_W-1:SPLIT]),
      .cin  (s1_q.c_mid),
      .sum  (hi_sum),
      .cout (hi_cout)
   );

   // Flow control: stage 2 takes a new entry when empty or being drained;
   // stage 1 accepts when empty or moving forward this cycle.
   assign adv2     = s1_valid_q & (~out_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | adv2;
   assign accept   = in_valid & in_ready;

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      if (accept) begin
         s1_d.a     = a_in;
         s1_d.b     = b_in;
         s1_d.lo    = {{HI_W{1'b0}}, lo_sum};
         s1_d.c_mid = lo_cout;
         s1_d.uns   = unsigned_in;
         s1_valid_d = 1'b1;
      end else if (adv2) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      a_out_d     = a_out_q;
      b_out_d     = b_out_q;
      sub_z_d     = sub_z_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      uns_d       = uns_q;
      if (adv2) begin
         out_valid_d = 1'b1;
         a_out_d     = s1_q.a;
         b_out_d     = s1_q.b;
         sub_z_d     = s1_q.lo | {hi_sum, {SPLIT{1'b0}}};
         carry_d     = hi_cout;
         ovf_d       = (s1_q.a[WORD_W-1] != s1_q.b[WORD_W-1]) &
                       (sub_z_d[WORD_W-1] != s1_q.a[WORD_W-1]);
         uns_d       = s1_q.uns;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         a_out_q     <= '0;
         b_out_q     <= '0;
         sub_z_q     <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         uns_q       <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         a_out_q     <= a_out_d;
         b_out_q     <= b_out_d;
         sub_z_q     <= sub_z_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         uns_q       <= uns_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign a_out        = a_out_q;
   assign b_out        = b_out_q;
   assign sub_z        = sub_z_q;
   assign carryout     = carry_q;
   assign overflow     = ovf_q;
   assign unsigned_out = uns_q;

endmodule

// File: tb/tb_sub_pipe_32.sv
// Scoreboard bench for sub_pipe_32: the driver pushes the hand-computed
// expected result on each accepted op, the monitor pops on each output handshake.
module tb_sub_pipe_32;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        unsigned_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] a_out;
   logic [31:0] b_out;
   logic [31:0] sub_z;
   logic        carryout;
   logic        overflow;
   logic        unsigned_out;

   sub_pipe_32 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a_in         (a_in),
      .b_in         (b_in),
      .unsigned_in  (unsigned_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .a_out        (a_out),
      .b_out        (b_out),
      .sub_z        (sub_z),
      .carryout     (carryout),
      .overflow     (overflow),
      .unsigned_out (unsigned_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
      logic        c;
      logic        v;
      logic        u;
   } vec_t;

   vec_t vecs[12];
   vec_t exp_q[$];
   int   pop_cyc[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: output handshake pops the scoreboard; a stall must hold data.
   logic        stall_prev = 1'b0;
   logic [31:0] snap_z, snap_b;

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            vec_t e;
            e = exp_q.pop_front();
            pop_cyc.push_back(cyc);
            chk("sub_z", sub_z, e.z);
            chk("carryout", {31'd0, carryout}, {31'd0, e.c});
            chk("overflow", {31'd0, overflow}, {31'd0, e.v});
            chk("a_out", a_out, e.a);
            chk("b_out", b_out, e.b);
            chk("unsigned_out", {31'd0, unsigned_out}, {31'd0, e.u});
         end
      end
      if (rst_n && out_valid && !out_ready) begin
         if (stall_prev) begin
            chk("stall_sub_z", sub_z, snap_z);
            chk("stall_b_out", b_out, snap_b);
         end
         snap_z     = sub_z;
         snap_b     = b_out;
         stall_prev = 1'b1;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Present vecs[idx] until accepted; called at posedge+1, returns at posedge+1.
   task automatic issue(input int idx, output int waits);
      logic done;
      done        = 1'b0;
      waits       = 0;
      in_valid    = 1'b1;
      a_in        = vecs[idx].a;
      b_in        = vecs[idx].b;
      unsigned_in = vecs[idx].u;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(vecs[idx]);
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 100) begin
               chk("issue_timeout", 32'd1, 32'd0);
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_left", exp_q.size(), 32'd0);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int w;
      int acc;
      int base;
      int pops_before;

      // a, b, a-b, carryout, overflow, unsigned
      vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{32'h0000_8000, 32'h0000_8001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      a_in        = '0;
      b_in        = '0;
      unsigned_in = 1'b0;
      out_ready   = 1'b1;

      // Reset state
      #3;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_sub_z", sub_z, 32'd0);
      chk("rst_flags", {29'd0, carryout, overflow, unsigned_out}, 32'd0);
      chk("rst_a_out", a_out, 32'd0);
      chk("rst_b_out", b_out, 32'd0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic op and two-cycle latency
      issue(0, w);
      in_valid = 1'b0;
      chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("lat_two", {31'd0, out_valid}, 32'd1);
      wait_drain();

      // Split borrow and signed overflow cases
      for (int i = 1; i <= 4; i++) issue(i, w);
      in_valid = 1'b0;
      wait_drain();

      // Streaming: 8 back-to-back ops with no stall
      base = pop_cyc.size();
      for (int i = 4; i < 12; i++) begin
         issue(i, w);
         chk("stream_in_ready", w, 32'd0);
      end
      in_valid = 1'b0;
      wait_drain();
      chk("stream_pops", pop_cyc.size() - base, 32'd8);
      if (pop_cyc.size() - base == 8) begin
         for (int i = 1; i < 8; i++)
            chk("stream_consec", pop_cyc[base + i] - pop_cyc[base + i - 1], 32'd1);
      end

      // Backpressure: only two ops fit, output held
      out_ready = 1'b0;
      acc       = 0;
      in_valid  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         a_in        = vecs[8 + acc].a;
         b_in        = vecs[8 + acc].b;
         unsigned_in = vecs[8 + acc].u;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(vecs[8 + acc]);
            acc++;
         end
         @(posedge clk);
         #1;
      end
      chk("bp_accepted", acc, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_head_z", sub_z, vecs[8].z);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // Asynchronous reset with two ops in flight
      issue(2, w);
      issue(3, w);
      in_valid = 1'b0;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_sub_z", sub_z, 32'd0);
      exp_q.delete();
      pops_before = pop_cyc.size();
      cycles(2);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      cycles(5);
      chk("no_stale", pop_cyc.size() - pops_before, 32'd0);

      // Pipeline still works after reset
      issue(5, w);
      in_valid = 1'b0;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sub_pipe_32.md
Name: sub_pipe_32

Overview:
- Two-stage pipelined 32-bit subtractor computing A - B as A + ~B + 1.
- Sits directly upstream of the comparison unit: supplies sub_z, carryout, the aligned operands A/B and unsigned_ctl for SLT/SLTU.
- Splits the carry chain at bit 16 to shorten the critical path.
- Valid/ready handshake on both sides, full throughput of 1 op/cycle.

Parameters:
- SPLIT, 16, bit position of the pipeline cut in the carry chain; legal range 1..31.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  block accepts when in_valid & in_ready
- a_in  in  32  minuend
- b_in  in  32  subtrahend
- unsigned_in  in  1  SLTU select, carried alongside the data
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream consumes when out_valid & out_ready
- a_out  out  32  A aligned with the result
- b_out  out  32  B aligned with the result
- sub_z  out  32  A - B modulo 2^32
- carryout  out  1  carry out of bit 31; 1 means no borrow (A >= B unsigned)
- overflow  out  1  signed overflow: (A[31] != B[31]) & (sub_z[31] != A[31])
- unsigned_out  out  1  aligned unsigned_in

Behaviour:
- Reset (async assert, sync release):
  - s1_valid = 0, out_valid = 0.
  - All data registers cleared to 0, so sub_z = 0, carryout = 0, overflow = 0, a_out = b_out = 0, unsigned_out = 0.
  - A reset mid-operation discards all in-flight ops; no partial result is ever presented.
- Stage 1 (on handshake):
  - Register lo = a[SPLIT-1:0] + ~b[SPLIT-1:0] + 1, with c_mid = carry out of that sum.
  - Register a_in, b_in and unsigned_in; set s1_valid = 1.
- Stage 2 (when stage 2 is free):
  - hi = a[31:SPLIT] + ~b[31:SPLIT] + c_mid.
  - sub_z = {hi, lo}; carryout = carry out of hi; overflow as defined above.
  - Pass A, B and unsigned through; set out_valid = 1.
- Latency: a result appears exactly 2 cycles after acceptance when there is no backpressure.
- Flow control, per-stage enable:
  - adv2 = s1_valid & (~out_valid | out_ready)
  - in_ready = ~s1_valid | adv2
  - in_ready is combinational from out_ready; no skid buffer.
- Register updates:
  - When out_valid & out_ready & ~adv2, out_valid drops to 0.
  - When s1_valid & adv2 & ~(in_valid & in_ready), s1_valid drops to 0.
- Simultaneous events:
  - Accept, advance and drain in the same cycle are all legal; the pipeline with 2 entries and out_ready held high runs at 1 op/cycle.
- Full condition: out_valid = 1, out_ready = 0, s1_valid = 1 gives in_ready = 0.
  - All output registers hold stable until the result is consumed; data must not change while out_valid & ~out_ready.
- Empty: out_valid = 0; the output data registers keep their last values and must not be relied upon.
- Ordering: strictly FIFO, no reordering, no drop, no duplication.
- Arithmetic:
  - All sums use an explicit 1-bit carry extension; truncation to 32 bits only on sub_z.
  - Boundary: A == B gives sub_z = 0, carryout = 1.
  - Boundary: B = 0 gives carryout = 1.

Decomposition:
- Shared package `alu32_pkg`:
  - WORD_W = 32 constant.
  - SPLIT default.
  - Struct/typedef for the stage-1 payload {a, b, lo, c_mid, uns}.
- One natural sub-module: `add_slice` (width param, inputs x, y, cin; outputs sum, cout).
  - Instantiated twice: low slice with cin = 1, high slice with cin = c_mid. The B inversion is done outside the slice.
- Downstream, the comparison unit connects directly to a_out, b_out, sub_z, carryout and unsigned_out.

Test Plan:
1. Basic: A = 5, B = 3, out_ready = 1 -> 2 cycles later sub_z = 0x00000002, carryout = 1, overflow = 0.
2. Borrow across the split: A = 0x0000FFFF, B = 0x00010000 -> sub_z = 0xFFFFFFFF, carryout = 0, overflow = 0. Also A = 0x00010000, B = 0x00000001 -> sub_z = 0x0000FFFF, carryout = 1.
3. Signed overflow: A = 0x80000000, B = 0x00000001 -> sub_z = 0x7FFFFFFF, overflow = 1, carryout = 1. A = 0x7FFFFFFF, B = 0xFFFFFFFF -> sub_z = 0x80000000, overflow = 1, carryout = 0.
4. Streaming: 8 back-to-back ops with out_ready = 1 -> in_ready stays 1 and 8 results arrive on consecutive cycles, in order, with unsigned_out matching.
5. Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> exactly 2 ops accepted, then in_ready = 0. Output stays stable on the first op. Releasing out_ready drains both in order with no loss.
6. Reset mid-op: assert rst_n = 0 asynchronously with 2 ops in flight -> out_valid = 0 and sub_z = 0 immediately, without waiting for a clock edge. After release, in_ready = 1 and no stale result is emitted.
